// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: tracks in-flight
// destinations, registers EX forwarding selects, raises load-use stalls and redirect flushes.
module hazard_fwd_unit #(
  parameter int unsigned RA_W       = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_en,
  input  logic                     id_valid,
  input  logic [RA_W-1:0]          id_rs1,
  input  logic [RA_W-1:0]          id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [RA_W-1:0]          id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     ex_redirect,
  output logic                     stall_if,
  output logic                     bubble_ex,
  output logic                     flush_id,
  output logic [$clog2(DEPTH)-1:0] fwd_rs1,
  output logic [$clog2(DEPTH)-1:0] fwd_rs2,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int unsigned FW = $clog2(DEPTH);
  localparam int unsigned NS = DEPTH - 1;

  // The oldest slot is never searched (regfile write-through covers it), so only
  // slots 0..DEPTH-2 are stored; dropping it on the shift is equivalent.
  logic            slot_valid [NS];
  logic [RA_W-1:0] slot_rd    [NS];
  logic            slot_rw    [NS];
  logic            slot_ld    [NS];

  logic          hit1, hit2;
  logic          near_ld1, near_ld2;
  logic [FW-1:0] sel1, sel2;
  logic          load_use;
  logic          redirect;
  logic          stall;

  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    near_ld1 = 1'b0;
    near_ld2 = 1'b0;
    sel1     = '0;
    sel2     = '0;
    // Walk oldest to youngest so the youngest match overwrites older ones.
    for (int unsigned k = 0; k < NS; k++) begin
      int unsigned j;
      j = NS - 1 - k;
      if (slot_valid[j] && slot_rw[j] && (slot_rd[j] == id_rs1) &&
          (id_rs1 != '0) && id_use_rs1) begin
        hit1     = 1'b1;
        sel1     = FW'(j + 1);
        near_ld1 = slot_ld[j] && ((j + 1) < LOAD_STAGE);
      end
      if (slot_valid[j] && slot_rw[j] && (slot_rd[j] == id_rs2) &&
          (id_rs2 != '0) && id_use_rs2) begin
        hit2     = 1'b1;
        sel2     = FW'(j + 1);
        near_ld2 = slot_ld[j] && ((j + 1) < LOAD_STAGE);
      end
    end
  end

  always_comb begin
    load_use  = id_valid && ((hit1 && near_ld1) || (hit2 && near_ld2));
    redirect  = rst_n && ex_redirect;
    stall     = rst_n && !ex_redirect && load_use;
    stall_if  = stall;
    bubble_ex = stall || redirect;
    flush_id  = redirect;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < NS; j++) begin
        slot_valid[j] <= 1'b0;
        slot_rd[j]    <= '0;
        slot_rw[j]    <= 1'b0;
        slot_ld[j]    <= 1'b0;
      end
      fwd_rs1 <= '0;
      fwd_rs2 <= '0;
    end else if (pipe_en) begin
      for (int unsigned j = 1; j < NS; j++) begin
        slot_valid[j] <= slot_valid[j-1];
        slot_rd[j]    <= slot_rd[j-1];
        slot_rw[j]    <= slot_rw[j-1];
        slot_ld[j]    <= slot_ld[j-1];
      end
      slot_valid[0] <= id_valid && !bubble_ex;
      slot_rd[0]    <= id_rd;
      slot_rw[0]    <= id_regwrite;
      slot_ld[0]    <= id_memread;
      fwd_rs1       <= bubble_ex ? '0 : (hit1 ? sel1 : '0);
      fwd_rs2       <= bubble_ex ? '0 : (hit2 ? sel2 : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (pipe_en) begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: vector table for hazard/forwarding cases plus
// hand sequences for pipe_en hold, reset mid-stall and counter saturation.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst_n, pipe_en, id_valid, id_use_rs1, id_use_rs2;
  logic       id_regwrite, id_memread, ex_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_if, bubble_ex, flush_id;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic [15:0] stall_cnt, flush_cnt;
  logic       s_stall_if, s_bubble_ex, s_flush_id;
  logic [1:0] s_fwd_rs1, s_fwd_rs2;
  logic [2:0] s_stall_cnt, s_flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_redirect(ex_redirect), .stall_if(stall_if), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used to reach saturation quickly.
  hazard_fwd_unit #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_redirect(ex_redirect), .stall_if(s_stall_if), .bubble_ex(s_bubble_ex),
    .flush_id(s_flush_id), .fwd_rs1(s_fwd_rs1), .fwd_rs2(s_fwd_rs2),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, ld, redir;
    logic       e_stall, e_bubble, e_flush;
    logic [1:0] e_f1, e_f2;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic redir);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = ld; ex_redirect = redir;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic ld, input logic redir,
                              input logic es, input logic eb, input logic ef,
                              input logic [1:0] f1, input logic [1:0] f2);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
    r.rw = rw; r.ld = ld; r.redir = redir;
    r.e_stall = es; r.e_bubble = eb; r.e_flush = ef; r.e_f1 = f1; r.e_f2 = f2;
    return r;
  endfunction

  initial begin
    //            v  rs1 rs2 u1 u2 rd  rw ld rd | st bu fl f1 f2
    vecs[0]  = mk(1,  2,  3, 1, 1,  1, 1, 0, 0,  0, 0, 0, 0, 0); // add x1
    vecs[1]  = mk(1,  1,  3, 1, 1,  2, 1, 0, 0,  0, 0, 0, 1, 0); // add x2,x1,x3
    vecs[2]  = mk(1, 10,  0, 1, 0,  5, 1, 1, 0,  0, 0, 0, 0, 0); // lw x5
    vecs[3]  = mk(1,  5,  5, 1, 1,  6, 1, 0, 0,  1, 1, 0, 0, 0); // add x6,x5,x5 stalls
    vecs[4]  = mk(1,  5,  5, 1, 1,  6, 1, 0, 0,  0, 0, 0, 2, 2); // retry -> fwd 2
    vecs[5]  = mk(1,  7,  0, 1, 0,  0, 1, 0, 0,  0, 0, 0, 0, 0); // write x0
    vecs[6]  = mk(1,  0,  0, 1, 1,  8, 1, 0, 0,  0, 0, 0, 0, 0); // read x0
    vecs[7]  = mk(1,  9,  9, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0, 0); // write x3
    vecs[8]  = mk(1,  9,  0, 1, 0,  3, 1, 0, 0,  0, 0, 0, 0, 0); // write x3 again
    vecs[9]  = mk(1,  3,  3, 1, 1, 10, 1, 0, 0,  0, 0, 0, 1, 1); // youngest wins
    vecs[10] = mk(1,  9,  0, 1, 0,  3, 1, 0, 0,  0, 0, 0, 0, 0); // write x3
    vecs[11] = mk(1,  9,  0, 1, 0, 11, 1, 0, 0,  0, 0, 0, 0, 0);
    vecs[12] = mk(1,  3,  0, 1, 0, 12, 1, 0, 0,  0, 0, 0, 2, 0); // distance 2
    vecs[13] = mk(1,  3,  0, 1, 0, 13, 1, 0, 0,  0, 0, 0, 0, 0); // distance 3
    vecs[14] = mk(1,  9,  0, 1, 0,  7, 1, 1, 0,  0, 0, 0, 0, 0); // lw x7
    vecs[15] = mk(1,  7,  0, 1, 0, 15, 1, 0, 1,  0, 1, 1, 0, 0); // redirect beats load-use
    vecs[16] = mk(1,  7,  0, 1, 0, 16, 1, 0, 0,  0, 0, 0, 2, 0);
    vecs[17] = mk(1,  9,  0, 1, 0,  4, 1, 1, 0,  0, 0, 0, 0, 0); // lw x4
    vecs[18] = mk(0,  4,  0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 1, 0); // no consumer: no stall

    rst_n = 1'b0; pipe_en = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("reset_fwd_rs1", 32'(fwd_rs1), 0);
    chk("reset_fwd_rs2", 32'(fwd_rs2), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].redir);
      #2;
      chk($sformatf("v%0d_stall_if", i),  32'(stall_if),  32'(vecs[i].e_stall));
      chk($sformatf("v%0d_bubble_ex", i), 32'(bubble_ex), 32'(vecs[i].e_bubble));
      chk($sformatf("v%0d_flush_id", i),  32'(flush_id),  32'(vecs[i].e_flush));
      step();
      chk($sformatf("v%0d_fwd_rs1", i), 32'(fwd_rs1), 32'(vecs[i].e_f1));
      chk($sformatf("v%0d_fwd_rs2", i), 32'(fwd_rs2), 32'(vecs[i].e_f2));
    end
    chk("tbl_stall_cnt", 32'(stall_cnt), 1);
    chk("tbl_flush_cnt", 32'(flush_cnt), 1);

    // pipe_en=0 freezes tracker, forwarding and counters
    drive(1, 9, 0, 1, 0, 20, 1, 1, 0); step();
    pipe_en = 1'b0;
    drive(1, 20, 0, 1, 0, 21, 1, 0, 0); #2;
    chk("hold_stall_if", 32'(stall_if), 1);
    step();
    chk("hold_stall_cnt", 32'(stall_cnt), 1);
    chk("hold_stall_if_again", 32'(stall_if), 1);
    pipe_en = 1'b1; step();
    chk("resume_stall_cnt", 32'(stall_cnt), 2);
    chk("resume_fwd_rs1", 32'(fwd_rs1), 0);
    step();
    chk("resume_fwd_rs1_2", 32'(fwd_rs1), 2);
    pipe_en = 1'b0;
    drive(1, 9, 0, 1, 0, 22, 1, 0, 0); step();
    chk("hold_fwd_rs1", 32'(fwd_rs1), 2);
    pipe_en = 1'b1;

    // reset in the middle of a load-use stall
    drive(1, 9, 0, 1, 0, 22, 1, 1, 0); step();
    drive(1, 22, 0, 1, 0, 23, 1, 0, 0); #2;
    chk("pre_rst_stall_if", 32'(stall_if), 1);
    rst_n = 1'b0; #1;
    chk("rst_stall_if", 32'(stall_if), 0);
    chk("rst_bubble_ex", 32'(bubble_ex), 0);
    step();
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    chk("rst_fwd_rs1", 32'(fwd_rs1), 0);
    rst_n = 1'b1; #1;
    chk("post_rst_stall_if", 32'(stall_if), 0);

    // saturation on the 3-bit copy, plain counting on the 16-bit one
    for (int i = 0; i < 9; i++) begin
      drive(1, 9, 0, 1, 0, 24, 1, 1, 0); step();
      drive(1, 24, 0, 1, 0, 25, 1, 0, 0); step();
    end
    for (int i = 0; i < 9; i++) begin
      drive(1, 9, 0, 0, 0, 26, 1, 0, 1); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_stall_cnt", 32'(s_stall_cnt), 7);
    chk("sat_flush_cnt", 32'(s_flush_cnt), 7);
    chk("main_stall_cnt", 32'(stall_cnt), 9);
    chk("main_flush_cnt", 32'(flush_cnt), 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
